// File: rtl/ram_port_arbiter.sv
// Two-requester (CPU data port, loader/debug port) arbiter in front of a single-port 32-bit RAM.
// Optional build macro RAM_PORT_ARBITER_ROUND_ROBIN_EN swaps loader priority for round-robin.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_CONSEC = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpuReadEn,
  input  logic                  cpuWriteEn,
  input  logic [ADDR_WIDTH-1:0] cpuAddr,
  input  logic [DATA_WIDTH-1:0] cpuWdata,
  output logic [DATA_WIDTH-1:0] cpuRdata,
  output logic                  cpuAck,
  output logic                  cpuStall,
  input  logic                  ldReq,
  input  logic                  ldWe,
  input  logic [ADDR_WIDTH-1:0] ldAddr,
  input  logic [DATA_WIDTH-1:0] ldWdata,
  output logic [DATA_WIDTH-1:0] ldRdata,
  output logic                  ldAck,
  output logic [ADDR_WIDTH-1:0] ramAddr,
  output logic [3:0]            ramWe,
  output logic [DATA_WIDTH-1:0] ramDin,
  input  logic [DATA_WIDTH-1:0] ramDout
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0] state;
  logic       cpu_req;
  logic       grant_any;
  logic       grant_ld;
  logic       lat_ld;
  logic       lat_we;

  assign cpu_req   = cpuReadEn | cpuWriteEn;
  assign grant_any = cpu_req | ldReq;
  assign cpuStall  = cpu_req & ~cpuAck & ~rst;

`ifdef RAM_PORT_ARBITER_ROUND_ROBIN_EN
  logic       last_ld;
  logic [3:0] grant_cnt;

  assign grant_cnt = 4'd0;

  // Winner select: on contention the requester not granted last time wins
  always_comb begin
    grant_ld = 1'b0;
    if (ldReq && cpu_req) begin
      grant_ld = ~last_ld;
    end else begin
      grant_ld = ldReq;
    end
  end

  // Remember who was granted last (reset value: CPU)
  always_ff @(posedge clk) begin
    if (rst) begin
      last_ld <= 1'b0;
    end else if (state == IDLE && grant_any) begin
      last_ld <= grant_ld;
    end else begin
      last_ld <= last_ld;
    end
  end
`else
  localparam logic [3:0] MAX_CNT = 4'(MAX_CONSEC);
  logic [3:0] grant_cnt;

  // Winner select: loader first, unless it has starved a waiting CPU long enough
  always_comb begin
    grant_ld = 1'b0;
    if (ldReq && !(cpu_req && grant_cnt == MAX_CNT)) begin
      grant_ld = 1'b1;
    end else begin
      grant_ld = 1'b0;
    end
  end

  // Count loader grants made while the CPU is waiting
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= 4'd0;
    end else if (!cpu_req) begin
      grant_cnt <= 4'd0;
    end else if (state == IDLE && grant_any) begin
      grant_cnt <= grant_ld ? grant_cnt + 4'd1 : 4'd0;
    end else begin
      grant_cnt <= grant_cnt;
    end
  end
`endif

  // Access sequencer: grant/latch in IDLE, drive RAM in ISSUE, ack and capture in RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lat_ld   <= 1'b0;
      lat_we   <= 1'b0;
      ramAddr  <= '0;
      ramDin   <= '0;
      ramWe    <= 4'd0;
      cpuAck   <= 1'b0;
      ldAck    <= 1'b0;
      cpuRdata <= '0;
      ldRdata  <= '0;
    end else begin
      cpuAck <= 1'b0;
      ldAck  <= 1'b0;
      ramWe  <= 4'd0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            state  <= ISSUE;
            lat_ld <= grant_ld;
            // ramAddr/ramDin double as the latched request; the requester may change now
            if (grant_ld) begin
              ramAddr <= ldAddr;
              ramDin  <= ldWdata;
              lat_we  <= ldWe;
              ramWe   <= {4{ldWe}};
            end else begin
              ramAddr <= cpuAddr;
              ramDin  <= cpuWdata;
              lat_we  <= cpuWriteEn;
              ramWe   <= {4{cpuWriteEn}};
            end
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          state <= RESP;
          if (lat_ld) begin
            ldAck <= 1'b1;
          end else begin
            cpuAck <= 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
          if (!lat_we && lat_ld) begin
            ldRdata <= ramDout;
          end else if (!lat_we) begin
            cpuRdata <= ramDout;
          end else begin
            ldRdata <= ldRdata;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: stimulus pushes expected acks/read data, a monitor pops and compares.
module tb_ram_port_arbiter;

`ifdef RAM_PORT_ARBITER_ROUND_ROBIN_EN
  localparam int LD_BEFORE_CPU = 1;
`else
  localparam int LD_BEFORE_CPU = 4;
`endif

  logic        clk;
  logic        rst;
  logic        cpuReadEn, cpuWriteEn;
  logic [31:0] cpuAddr, cpuWdata, cpuRdata;
  logic        cpuAck, cpuStall;
  logic        ldReq, ldWe;
  logic [31:0] ldAddr, ldWdata, ldRdata;
  logic        ldAck;
  logic [31:0] ramAddr;
  logic [3:0]  ramWe;
  logic [31:0] ramDin, ramDout;

  ram_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_CONSEC(4)) dut (
    .clk(clk), .rst(rst),
    .cpuReadEn(cpuReadEn), .cpuWriteEn(cpuWriteEn), .cpuAddr(cpuAddr), .cpuWdata(cpuWdata),
    .cpuRdata(cpuRdata), .cpuAck(cpuAck), .cpuStall(cpuStall),
    .ldReq(ldReq), .ldWe(ldWe), .ldAddr(ldAddr), .ldWdata(ldWdata),
    .ldRdata(ldRdata), .ldAck(ldAck),
    .ramAddr(ramAddr), .ramWe(ramWe), .ramDin(ramDin), .ramDout(ramDout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM model: write on nonzero ramWe, read data one cycle later
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (ramWe != 4'd0) mem[ramAddr[7:2]] <= ramDin;
    ramDout <= mem[ramAddr[7:2]];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        ld;
    logic        rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  logic pend_cpu = 1'b0, pend_ld = 1'b0;
  logic [31:0] pend_data = 32'd0;

  // Monitor: every ack pops one expectation; read data is checked the cycle after the ack
  always @(negedge clk) begin
    exp_t e;
    if (pend_cpu) chk("cpu_rdata", cpuRdata, pend_data);
    if (pend_ld)  chk("ld_rdata", ldRdata, pend_data);
    pend_cpu <= 1'b0;
    pend_ld  <= 1'b0;
    if (cpuAck || ldAck) begin
      if (sb.size() == 0) begin
        chk("spurious_ack", {30'd0, cpuAck, ldAck}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ack_owner", {30'd0, cpuAck, ldAck}, e.ld ? 32'd1 : 32'd2);
        if (e.rd) begin
          pend_data <= e.data;
          if (e.ld) pend_ld <= 1'b1;
          else      pend_cpu <= 1'b1;
        end
      end
    end
  end

  task automatic push(input logic ld, input logic rd, input logic [31:0] data);
    exp_t e;
    e.ld = ld; e.rd = rd; e.data = data;
    sb.push_back(e);
  endtask

  // Present one request, hold it until its ack (bounded), then drop it
  task automatic access(input logic is_ld, input logic we, input logic [31:0] addr, input logic [31:0] data);
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    if (is_ld) begin
      ldReq = 1'b1; ldWe = we; ldAddr = addr; ldWdata = data;
    end else begin
      cpuReadEn = ~we; cpuWriteEn = we; cpuAddr = addr; cpuWdata = data;
    end
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (is_ld ? ldAck : cpuAck) seen = 1'b1;
    end
    ldReq = 1'b0; cpuReadEn = 1'b0; cpuWriteEn = 1'b0;
    chk("access_ack_seen", {31'd0, seen}, 32'd1);
  endtask

  initial begin
    logic cpu_done, done;
    int   nld;
    rst = 1'b1;
    cpuReadEn = 1'b0; cpuWriteEn = 1'b0; cpuAddr = 32'd0; cpuWdata = 32'd0;
    ldReq = 1'b0; ldWe = 1'b0; ldAddr = 32'd0; ldWdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_ramWe", {28'd0, ramWe}, 32'd0);
    chk("rst_ramAddr", ramAddr, 32'd0);
    chk("rst_acks", {30'd0, cpuAck, ldAck}, 32'd0);
    chk("rst_rdata", cpuRdata | ldRdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_stall", {31'd0, cpuStall}, 32'd0);

    // Test 1: loader write alone, cycle-exact
    push(1'b1, 1'b0, 32'd0);
    ldReq = 1'b1; ldWe = 1'b1; ldAddr = 32'h10; ldWdata = 32'hDEADBEEF;
    for (int c = 0; c < 3; c++) begin
      if (c == 0) #1; else @(negedge clk);
      chk($sformatf("t1_ramWe_c%0d", c), {28'd0, ramWe}, (c == 1) ? 32'hF : 32'h0);
      chk($sformatf("t1_ldAck_c%0d", c), {31'd0, ldAck}, (c == 2) ? 32'd1 : 32'd0);
      chk($sformatf("t1_stall_c%0d", c), {31'd0, cpuStall}, 32'd0);
      if (c == 1) chk("t1_ramDin", ramDin, 32'hDEADBEEF);
    end
    ldReq = 1'b0;

    // Test 2: CPU read of the same word
    @(negedge clk);
    push(1'b0, 1'b1, 32'hDEADBEEF);
    cpuReadEn = 1'b1; cpuAddr = 32'h10;
    for (int c = 0; c < 3; c++) begin
      if (c == 0) #1; else @(negedge clk);
      chk($sformatf("t2_stall_c%0d", c), {31'd0, cpuStall}, (c < 2) ? 32'd1 : 32'd0);
      chk($sformatf("t2_cpuAck_c%0d", c), {31'd0, cpuAck}, (c == 2) ? 32'd1 : 32'd0);
    end
    cpuReadEn = 1'b0;

    // Test 3: simultaneous requests, loader first
    @(negedge clk);
    push(1'b1, 1'b0, 32'd0);
    push(1'b0, 1'b1, 32'h11111111);
    ldReq = 1'b1; ldWe = 1'b1; ldAddr = 32'h20; ldWdata = 32'h11111111;
    cpuReadEn = 1'b1; cpuAddr = 32'h20;
    for (int c = 0; c < 6; c++) begin
      if (c == 0) #1; else @(negedge clk);
      chk($sformatf("t3_ldAck_c%0d", c), {31'd0, ldAck}, (c == 2) ? 32'd1 : 32'd0);
      chk($sformatf("t3_cpuAck_c%0d", c), {31'd0, cpuAck}, (c == 5) ? 32'd1 : 32'd0);
      if (c == 2) ldReq = 1'b0;
    end
    cpuReadEn = 1'b0;

    // Test 4: loader streams while the CPU waits
    @(negedge clk);
    for (int i = 0; i < LD_BEFORE_CPU; i++) push(1'b1, 1'b0, 32'd0);
    push(1'b0, 1'b1, 32'hDEADBEEF);
    push(1'b1, 1'b0, 32'd0);
    ldReq = 1'b1; ldWe = 1'b1; ldAddr = 32'h40; ldWdata = 32'h22222222;
    cpuReadEn = 1'b1; cpuAddr = 32'h10;
    nld = 0; cpu_done = 1'b0; done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (cpuAck) begin
        cpu_done = 1'b1;
        cpuReadEn = 1'b0;
      end
      if (ldAck && !cpu_done) nld++;
      if (ldAck && cpu_done) begin
        ldReq = 1'b0;
        done = 1'b1;
      end
    end
    ldReq = 1'b0; cpuReadEn = 1'b0;
    chk("t4_completed", {31'd0, done}, 32'd1);
    chk("t4_ld_acks_before_cpu", 32'(nld), 32'(LD_BEFORE_CPU));

    // Test 5: reset during ISSUE of a CPU write
    @(negedge clk);
    cpuWriteEn = 1'b1; cpuAddr = 32'h50; cpuWdata = 32'h55AA55AA;
    #1;
    @(negedge clk);
    chk("t5_issue_ramWe", {28'd0, ramWe}, 32'hF);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_ramWe", {28'd0, ramWe}, 32'd0);
    chk("t5_rst_acks", {30'd0, cpuAck, ldAck}, 32'd0);
    chk("t5_rst_stall", {31'd0, cpuStall}, 32'd0);
    chk("t5_rst_ramAddr", ramAddr, 32'd0);
    chk("t5_rst_ramDin", ramDin, 32'd0);
    chk("t5_rst_rdata", cpuRdata | ldRdata, 32'd0);
    rst = 1'b0;
    cpuWriteEn = 1'b0;
    push(1'b0, 1'b0, 32'd0);
    access(1'b0, 1'b1, 32'h50, 32'h55AA55AA);
    push(1'b0, 1'b1, 32'h55AA55AA);
    access(1'b0, 1'b0, 32'h50, 32'd0);
    push(1'b1, 1'b1, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'h10, 32'd0);

    // Drain the scoreboard (bounded)
    for (int i = 0; i < 10 && (sb.size() != 0 || pend_cpu || pend_ld); i++) @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
